multi_port_fifo: RTL and testbench

//  In-order circular queue: accepts up to PUSH_PORTS entries per cycle, exposes its
//  POP_PORTS oldest entries in parallel and retires an in-order prefix of them per cycle.

---
 rtl/queue_pkg.sv | 27 ++
 rtl/mpf_prefix_mask.sv | 28 ++
 rtl/multi_port_fifo.sv | 129 ++++++++++++
 tb/tb_multi_port_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared helpers and sizing constants for the multi-port queue.
// Pointer and count widths are derived from the default depth of 8.
package queue_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned PTR_W         = $clog2(DEFAULT_DEPTH);
    localparam int unsigned CNT_W         = PTR_W + 1;

    // Length of the leading run of 1s starting at bit 0.
    function automatic int unsigned prefix_count(input logic [31:0] vec);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i] && (n == i)) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Pointer add modulo depth; depth must be a power of two.
    function automatic logic [31:0] wrap_add(input logic [31:0] ptr, input logic [31:0] n,
                                             input int unsigned depth);
        return (ptr + n) & (depth - 1);
    endfunction

endpackage

// File: rtl/mpf_prefix_mask.sv
// Accepts the in-order prefix of a request vector, limited by an availability vector.
// Returns the thermometer mask of accepted ports and how many there are.
module mpf_prefix_mask
    import queue_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]             req_i,
    input  logic [N-1:0]             avail_i,
    output logic [N-1:0]             mask_o,
    output logic [$clog2(N+1)-1:0]   cnt_o
);

    // A port is accepted only if every lower port requests and it is itself available.
    always_comb begin
        logic         run;
        logic [N-1:0] m;
        run = 1'b1;
        m   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            run  = run & req_i[i] & avail_i[i];
            m[i] = run;
        end
        mask_o = m;
        cnt_o  = ($clog2(N+1))'(prefix_count(32'(m)));
    end

endmodule

// File: rtl/multi_port_fifo.sv
// In-order circular queue: up to PUSH_PORTS writes per cycle, POP_PORTS oldest entries
// exposed in parallel, an in-order prefix of them retired per cycle. No bypass: a pushed
// entry is visible the cycle after it is written.
// Optional feature: define MPF_OCCUPANCY_EN to add the occupancy output port.
module multi_port_fifo
    import queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned PUSH_PORTS = 2,
    parameter int unsigned POP_PORTS  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [PUSH_PORTS-1:0]                 push,
    input  logic [PUSH_PORTS-1:0][DATA_WIDTH-1:0] push_data,
    output logic [PUSH_PORTS-1:0]                 ready_out,
    output logic [POP_PORTS-1:0]                  valid_out,
    output logic [POP_PORTS-1:0][DATA_WIDTH-1:0]  data_out,
    input  logic [POP_PORTS-1:0]                  pop
`ifdef MPF_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH):0]                occupancy
`endif
);

    localparam int unsigned PtrW     = $clog2(DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned PushCntW = $clog2(PUSH_PORTS + 1);
    localparam int unsigned PopCntW  = $clog2(POP_PORTS + 1);

    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PUSH_PORTS-1:0] push_mask;
    logic [POP_PORTS-1:0]  pop_mask;
    logic [PushCntW-1:0]   npush;
    logic [PopCntW-1:0]    npop;

    // Handshake decode from the registered count only, so freed slots appear next cycle.
    always_comb begin
        ready_out = '0;
        valid_out = '0;
        for (int unsigned i = 0; i < PUSH_PORTS; i++) begin
            ready_out[i] = (DEPTH - 32'(count_q)) > i;
        end
        for (int unsigned i = 0; i < POP_PORTS; i++) begin
            valid_out[i] = 32'(count_q) > i;
        end
    end

    mpf_prefix_mask #(
        .N (PUSH_PORTS)
    ) u_push_mask (
        .req_i   (push),
        .avail_i (ready_out),
        .mask_o  (push_mask),
        .cnt_o   (npush)
    );

    mpf_prefix_mask #(
        .N (POP_PORTS)
    ) u_pop_mask (
        .req_i   (pop),
        .avail_i (valid_out),
        .mask_o  (pop_mask),
        .cnt_o   (npop)
    );

    // Only the count of retired entries matters; the head pointer handles the rest.
    logic unused_pop_mask;
    assign unused_pop_mask = ^pop_mask;

    // Head entries read combinationally from storage; slots past the count are don't-care.
    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < POP_PORTS; i++) begin
            data_out[i] = mem_q[PtrW'(wrap_add(32'(head_q), i, DEPTH))];
        end
    end

    // Next pointers and count; flush discards this cycle's pushes and pops.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = PtrW'(wrap_add(32'(head_q), 32'(npop), DEPTH));
            tail_d  = PtrW'(wrap_add(32'(tail_q), 32'(npush), DEPTH));
            count_d = count_q + CntW'(npush) - CntW'(npop);
        end
    end

    // Pointer/count registers with synchronous reset taking priority over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; accepted pushes land at tail, tail+1, ... in port order.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PUSH_PORTS; i++) begin
            if (!rst && !flush && push_mask[i]) begin
                mem_q[PtrW'(wrap_add(32'(tail_q), i, DEPTH))] <= push_data[i];
            end
        end
    end

`ifdef MPF_OCCUPANCY_EN
    assign occupancy = count_q;
`else
    // Occupancy stays internal to the count register.
`endif

endmodule

// File: tb/tb_multi_port_fifo.sv
// Scoreboard bench for multi_port_fifo (DEPTH=8, 2 push ports, 2 pop ports, 32-bit data).
// The driver issues one cycle of stimulus, updates a reference queue and queues the state
// the DUT must show after the next edge; the monitor checks it on the falling edge.
module tb_multi_port_fifo;

    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [1:0]       push = 2'b00;
    logic [1:0]       pop = 2'b00;
    logic [1:0][31:0] push_data = '0;
    logic [1:0]       ready_out;
    logic [1:0]       valid_out;
    logic [1:0][31:0] data_out;
`ifdef MPF_OCCUPANCY_EN
    logic [3:0]       occupancy;
`endif

    multi_port_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .PUSH_PORTS (2),
        .POP_PORTS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .pop       (pop)
`ifdef MPF_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  v;
        logic [1:0]  r;
        int unsigned cnt;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] seq = 32'h0000_1000;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare the DUT against the expectation due this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            chk("valid_out", 32'(valid_out), 32'(mon_e.v));
            chk("ready_out", 32'(ready_out), 32'(mon_e.r));
`ifdef MPF_OCCUPANCY_EN
            chk("occupancy", 32'(occupancy), mon_e.cnt);
`endif
            if (mon_e.v[0]) chk("data_out[0]", data_out[0], mon_e.d0);
            if (mon_e.v[1]) chk("data_out[1]", data_out[1], mon_e.d1);
        end
    end

    // One stimulus cycle. With hand=1 the handshake/count expectations are the
    // hand-computed hv/hr/hc; data always comes from the reference queue.
    task automatic step(input logic [1:0] p, input logic [1:0] pp, input logic fl,
                        input logic rs, input logic hand, input logic [1:0] hv,
                        input logic [1:0] hr, input int unsigned hc);
        logic [31:0] d0, d1;
        int          c, np, npo;
        exp_t        e;
        d0 = seq;
        d1 = seq + 1;
        seq = seq + 2;
        push = p;
        pop = pp;
        flush = fl;
        rst = rs;
        push_data[0] = d0;
        push_data[1] = d1;
        if (rs || fl) begin
            mq.delete();
        end else begin
            c = mq.size();
            np = 0;
            npo = 0;
            if (p[0] && c < DEPTH) begin
                np = 1;
                if (p[1] && c < DEPTH - 1) np = 2;
            end
            if (pp[0] && c > 0) begin
                npo = 1;
                if (pp[1] && c > 1) npo = 2;
            end
            repeat (npo) void'(mq.pop_front());
            if (np >= 1) mq.push_back(d0);
            if (np == 2) mq.push_back(d1);
        end
        c = mq.size();
        e.cyc = cyc + 1;
        e.cnt = c;
        e.v = {c > 1, c > 0};
        e.r = {(DEPTH - c) > 1, (DEPTH - c) > 0};
        e.d0 = (c > 0) ? mq[0] : 32'h0;
        e.d1 = (c > 1) ? mq[1] : 32'h0;
        if (hand) begin
            e.v = hv;
            e.r = hr;
            e.cnt = hc;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then two entries in one cycle.
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 0);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2);
        // Fill to full, then push while full.
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 4);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 6);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 8);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 8);
        // One slot free: only port 0 may push.
        step(2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 7);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 8);
        // Flush, gap push on empty, pop on empty.
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 0);
        step(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 0);
        step(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 0);
        // Gap pop with two entries retires nothing.
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2);
        step(2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 4);
        // Steady push+pop at count 4; pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            step(2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 4);
        end
        // Flush with a concurrent push at count 5.
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 5);
        step(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 0);
        // Reset during traffic at count 3.
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 2);
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 2'b11, 3);
        step(2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 0);
        // Random soak against the reference queue.
        for (int i = 0; i < 10000; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 127) == 0), ($urandom_range(0, 511) == 0),
                 1'b0, 2'b00, 2'b00, 0);
        end
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
